program_loader: RTL and testbench

- Host-side front end directly upstream of the accelerator core.
- Accepts a 32-bit valid/ready word stream from the host and writes instruction words into the instruction store and NUM_SIZE-bit words into data memory.
- Holds the core in reset while loading, then releases it on a start command.
- Watches the core's halt flag and reports completion plus a run-cycle count.

---
 rtl/program_loader_pkg.sv | 34 +++
 rtl/program_loader_hdr_decode.sv | 31 +++
 rtl/program_loader.sv | 217 +++++++++++++++++++++
 tb/tb_program_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and header field layout for the program loader.
package program_loader_pkg;

  // Loader control states
  typedef enum logic [2:0] {
    IDLE,
    LOAD_I,
    LOAD_D,
    DRAIN,
    RUN
  } state_t;

  // Header type codes carried in the top two bits of a header word
  localparam logic [1:0] HDR_INSTR   = 2'd0;
  localparam logic [1:0] HDR_DATA    = 2'd1;
  localparam logic [1:0] HDR_START   = 2'd2;
  localparam logic [1:0] HDR_ILLEGAL = 2'd3;

  // Header field bit positions
  localparam int HDR_TYPE_MSB  = 31;
  localparam int HDR_TYPE_LSB  = 30;
  localparam int HDR_BASE_MSB  = 15;
  localparam int HDR_BASE_LSB  = 8;
  localparam int HDR_COUNT_MSB = 7;
  localparam int HDR_COUNT_LSB = 0;

  // Header fields that carry meaning; bits 29:16 are dropped before this point
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] base;
    logic [7:0] count;
  } hdr_t;

endpackage

// File: rtl/program_loader_hdr_decode.sv
// Combinational header split and destination range check.
module loader_hdr_decode
  import program_loader_pkg::*;
#(
  parameter int NUM_INSTRUCTIONS = 16,
  parameter int WORDS_IN_MEMORY  = 32,
  parameter int PTR_W            = 5
) (
  input  hdr_t             hdr,
  output logic [1:0]       kind,
  output logic [PTR_W-1:0] start_ptr,
  output logic [7:0]       count,
  output logic             empty,
  output logic             over_range
);

  logic [8:0] end_addr;
  logic [8:0] depth;

  // Split fields; base+count is formed in 9 bits so it cannot wrap
  always_comb begin
    kind       = hdr.kind;
    count      = hdr.count;
    start_ptr  = hdr.base[PTR_W-1:0];
    empty      = (hdr.count == 8'd0);
    end_addr   = {1'b0, hdr.base} + {1'b0, hdr.count};
    depth      = (hdr.kind == HDR_INSTR) ? 9'(NUM_INSTRUCTIONS) : 9'(WORDS_IN_MEMORY);
    over_range = (end_addr > depth);
  end

endmodule

// File: rtl/program_loader.sv
// Host word-stream loader: fills instruction and data stores, runs the core,
// and reports completion with a run-cycle count.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int NUM_SIZE         = 16,
  parameter int NUM_INSTRUCTIONS = 16,
  parameter int WORDS_IN_MEMORY  = 32,
  parameter int CYCLE_CNT_W      = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [31:0]                         s_data,
  output logic                                instr_we,
  output logic [$clog2(NUM_INSTRUCTIONS)-1:0] instr_addr,
  output logic [31:0]                         instr_wdata,
  output logic                                mem_we,
  output logic [$clog2(WORDS_IN_MEMORY)-1:0]  mem_addr,
  output logic [NUM_SIZE-1:0]                 mem_wdata,
  output logic                                acc_rst,
  input  logic                                acc_halted,
  output logic                                done,
  output logic                                err,
  output logic [CYCLE_CNT_W-1:0]              run_cycles
);

  localparam int IA_W  = $clog2(NUM_INSTRUCTIONS);
  localparam int DA_W  = $clog2(WORDS_IN_MEMORY);
  localparam int PTR_W = (IA_W > DA_W) ? IA_W : DA_W;

  state_t                 state_reg,       state_next;
  logic                   s_ready_reg,     s_ready_next;
  logic [PTR_W-1:0]       ptr_reg,         ptr_next;
  logic [7:0]             remaining_reg,   remaining_next;
  logic                   instr_we_reg,    instr_we_next;
  logic [IA_W-1:0]        instr_addr_reg,  instr_addr_next;
  logic [31:0]            instr_wdata_reg, instr_wdata_next;
  logic                   mem_we_reg,      mem_we_next;
  logic [DA_W-1:0]        mem_addr_reg,    mem_addr_next;
  logic [NUM_SIZE-1:0]    mem_wdata_reg,   mem_wdata_next;
  logic                   acc_rst_reg,     acc_rst_next;
  logic                   done_reg,        done_next;
  logic                   err_reg,         err_next;
  logic [CYCLE_CNT_W-1:0] run_cycles_reg,  run_cycles_next;
  logic                   first_run_reg,   first_run_next;

  hdr_t             hdr_word;
  logic [1:0]       hdr_kind;
  logic [PTR_W-1:0] hdr_ptr;
  logic [7:0]       hdr_count;
  logic             hdr_empty;
  logic             hdr_over;
  logic             handshake;

  assign handshake = s_valid && s_ready_reg;
  assign hdr_word  = {s_data[HDR_TYPE_MSB:HDR_TYPE_LSB],
                      s_data[HDR_BASE_MSB:HDR_BASE_LSB],
                      s_data[HDR_COUNT_MSB:HDR_COUNT_LSB]};

  loader_hdr_decode #(
    .NUM_INSTRUCTIONS (NUM_INSTRUCTIONS),
    .WORDS_IN_MEMORY  (WORDS_IN_MEMORY),
    .PTR_W            (PTR_W)
  ) u_hdr_decode (
    .hdr        (hdr_word),
    .kind       (hdr_kind),
    .start_ptr  (hdr_ptr),
    .count      (hdr_count),
    .empty      (hdr_empty),
    .over_range (hdr_over)
  );

  // Next-state and registered-output logic; strobes and done default low
  always_comb begin
    state_next       = state_reg;
    ptr_next         = ptr_reg;
    remaining_next   = remaining_reg;
    instr_we_next    = 1'b0;
    instr_addr_next  = instr_addr_reg;
    instr_wdata_next = instr_wdata_reg;
    mem_we_next      = 1'b0;
    mem_addr_next    = mem_addr_reg;
    mem_wdata_next   = mem_wdata_reg;
    done_next        = 1'b0;
    err_next         = err_reg;
    run_cycles_next  = run_cycles_reg;
    first_run_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (handshake) begin
          case (hdr_kind)
            HDR_INSTR, HDR_DATA: begin
              if (hdr_empty) begin
                state_next = IDLE;
              end else if (hdr_over) begin
                err_next       = 1'b1;
                state_next     = DRAIN;
                remaining_next = hdr_count;
              end else begin
                state_next     = (hdr_kind == HDR_INSTR) ? LOAD_I : LOAD_D;
                ptr_next       = hdr_ptr;
                remaining_next = hdr_count;
              end
            end
            HDR_START: begin
              state_next      = RUN;
              run_cycles_next = '0;
              first_run_next  = 1'b1;
            end
            default: begin
              err_next = 1'b1;
            end
          endcase
        end
      end

      LOAD_I: begin
        if (handshake) begin
          instr_we_next    = 1'b1;
          instr_addr_next  = ptr_reg[IA_W-1:0];
          instr_wdata_next = s_data;
          ptr_next         = ptr_reg + PTR_W'(1);
          remaining_next   = remaining_reg - 8'd1;
          if (remaining_reg == 8'd1) state_next = IDLE;
        end
      end

      LOAD_D: begin
        if (handshake) begin
          mem_we_next    = 1'b1;
          mem_addr_next  = ptr_reg[DA_W-1:0];
          mem_wdata_next = s_data[NUM_SIZE-1:0];
          ptr_next       = ptr_reg + PTR_W'(1);
          remaining_next = remaining_reg - 8'd1;
          if (remaining_reg == 8'd1) state_next = IDLE;
        end
      end

      DRAIN: begin
        if (handshake) begin
          remaining_next = remaining_reg - 8'd1;
          if (remaining_reg == 8'd1) state_next = IDLE;
        end
      end

      RUN: begin
        if (run_cycles_reg != '1) run_cycles_next = run_cycles_reg + CYCLE_CNT_W'(1);
        // The core is still leaving reset during its first RUN cycle
        if (!first_run_reg && acc_halted) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Core runs and the host is stalled only while in RUN
    s_ready_next = (state_next != RUN);
    acc_rst_next = (state_next != RUN);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      s_ready_reg     <= 1'b0;
      ptr_reg         <= '0;
      remaining_reg   <= '0;
      instr_we_reg    <= 1'b0;
      instr_addr_reg  <= '0;
      instr_wdata_reg <= '0;
      mem_we_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      acc_rst_reg     <= 1'b1;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      run_cycles_reg  <= '0;
      first_run_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      s_ready_reg     <= s_ready_next;
      ptr_reg         <= ptr_next;
      remaining_reg   <= remaining_next;
      instr_we_reg    <= instr_we_next;
      instr_addr_reg  <= instr_addr_next;
      instr_wdata_reg <= instr_wdata_next;
      mem_we_reg      <= mem_we_next;
      mem_addr_reg    <= mem_addr_next;
      mem_wdata_reg   <= mem_wdata_next;
      acc_rst_reg     <= acc_rst_next;
      done_reg        <= done_next;
      err_reg         <= err_next;
      run_cycles_reg  <= run_cycles_next;
      first_run_reg   <= first_run_next;
    end
  end

  assign s_ready     = s_ready_reg;
  assign instr_we    = instr_we_reg;
  assign instr_addr  = instr_addr_reg;
  assign instr_wdata = instr_wdata_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign acc_rst     = acc_rst_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign run_cycles  = run_cycles_reg;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: drives and samples on the falling edge.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        instr_we;
  logic [3:0]  instr_addr;
  logic [31:0] instr_wdata;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        acc_rst;
  logic        acc_halted;
  logic        done;
  logic        err;
  logic [31:0] run_cycles;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int overlap = 0;

  int unsigned i_addr_q[$];
  logic [31:0] i_data_q[$];
  int          i_cyc_q[$];
  int unsigned m_addr_q[$];
  logic [31:0] m_data_q[$];

  logic [31:0] exp_i [3] = '{32'h0004_2000, 32'h0028_0000, 32'h0000_0001};

  program_loader dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .instr_we    (instr_we),
    .instr_addr  (instr_addr),
    .instr_wdata (instr_wdata),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .acc_rst     (acc_rst),
    .acc_halted  (acc_halted),
    .done        (done),
    .err         (err),
    .run_cycles  (run_cycles)
  );

  always #5 clk = ~clk;

  // Log every write strobe seen on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (instr_we) begin
      i_addr_q.push_back(int'(instr_addr));
      i_data_q.push_back(instr_wdata);
      i_cyc_q.push_back(cyc);
    end
    if (mem_we) begin
      m_addr_q.push_back(int'(mem_addr));
      m_data_q.push_back({16'd0, mem_wdata});
    end
    if (instr_we && mem_we) overlap++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [1:0] t, input logic [7:0] b, input logic [7:0] c);
    return {t, 14'h1555, b, c};
  endfunction

  // Present one word and return on the falling edge after its handshake
  task automatic send(input logic [31:0] w);
    int guard;
    guard = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("send_timeout", 64'd0, 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = 32'hDEAD_BEEF;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    i_addr_q.delete(); i_data_q.delete(); i_cyc_q.delete();
    m_addr_q.delete(); m_data_q.delete();
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_s_ready"},    s_ready,    0);
    check({pfx, "_acc_rst"},    acc_rst,    1);
    check({pfx, "_done"},       done,       0);
    check({pfx, "_err"},        err,        0);
    check({pfx, "_run_cycles"}, run_cycles, 0);
    check({pfx, "_instr_we"},   instr_we,   0);
    check({pfx, "_mem_we"},     mem_we,     0);
    check({pfx, "_addrs"},      {instr_addr, mem_addr}, 0);
    check({pfx, "_wdata"},      {instr_wdata, mem_wdata}, 0);
  endtask

  initial begin
    int bad;
    rst = 1'b1; s_valid = 1'b0; s_data = 32'h0; acc_halted = 1'b0;

    // Reset state
    idle(3);
    check_reset_values("rst");
    rst = 1'b0;
    idle(1);
    check("rst_release_s_ready", s_ready, 1);

    // Instruction load: three consecutive strobes at 2,3,4
    clear_logs();
    send(hdr(2'd0, 8'd2, 8'd3));
    for (int i = 0; i < 3; i++) send(exp_i[i]);
    idle(3);
    check("iload_count", i_addr_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("iload_addr%0d", i), (i < i_addr_q.size()) ? i_addr_q[i] : 32'hFFFF, 2 + i);
      check($sformatf("iload_data%0d", i), (i < i_data_q.size()) ? i_data_q[i] : 32'hFFFF_FFFF, exp_i[i]);
    end
    check("iload_back_to_back", (i_cyc_q.size() == 3) ? (i_cyc_q[2] - i_cyc_q[0]) : -1, 2);
    check("iload_no_mem_we", m_addr_q.size(), 0);

    // Data load with s_valid toggled every other cycle
    clear_logs();
    send(hdr(2'd1, 8'd8, 8'd4));
    for (int i = 0; i < 4; i++) begin
      idle(1);
      send(32'hABCD_0005 + i);
    end
    idle(3);
    check("dload_count", m_addr_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("dload_addr%0d", i), (i < m_addr_q.size()) ? m_addr_q[i] : 32'hFFFF, 8 + i);
      check($sformatf("dload_data%0d", i), (i < m_data_q.size()) ? m_data_q[i] : 32'hFFFF_FFFF, 5 + i);
    end
    check("dload_no_instr_we", i_addr_q.size(), 0);

    // Load ending exactly at the top of data memory is legal
    clear_logs();
    send(hdr(2'd1, 8'd30, 8'd2));
    send(32'h0000_0111);
    send(32'h0000_0222);
    idle(3);
    check("edge_err_clear", err, 0);
    check("edge_count", m_addr_q.size(), 2);
    check("edge_last_addr", (m_addr_q.size() == 2) ? m_addr_q[1] : 32'hFFFF, 31);
    check("edge_last_data", (m_data_q.size() == 2) ? m_data_q[1] : 32'hFFFF_FFFF, 32'h222);

    // Run with a late halt: 21 RUN cycles, one done pulse
    send(hdr(2'd2, 8'd0, 8'd0));
    bad = 0;
    for (int i = 1; i <= 21; i++) begin
      if (s_ready || acc_rst || done) bad++;
      acc_halted = (i == 21);
      @(negedge clk);
    end
    acc_halted = 1'b0;
    check("run_ready_rst_low", bad, 0);
    check("run_done_pulse", done, 1);
    check("run_cycles_21", run_cycles, 21);
    check("run_acc_rst_back", acc_rst, 1);
    check("run_s_ready_back", s_ready, 1);
    idle(1);
    check("run_done_single", done, 0);
    check("run_cycles_held", run_cycles, 21);

    // Halt already high on the first RUN cycle is ignored
    acc_halted = 1'b1;
    send(hdr(2'd2, 8'd0, 8'd0));
    check("early_halt_c1_done", done, 0);
    idle(1);
    check("early_halt_c2_done", done, 0);
    idle(1);
    check("early_halt_done", done, 1);
    check("early_halt_cycles", run_cycles, 2);
    acc_halted = 1'b0;

    // Range error: payload drained without strobes, then recovery
    clear_logs();
    send(hdr(2'd1, 8'd30, 8'd4));
    for (int i = 0; i < 4; i++) send(32'h0000_0F00 + i);
    idle(3);
    check("range_err", err, 1);
    check("range_no_mem_we", m_addr_q.size(), 0);
    send(hdr(2'd1, 8'd0, 8'd1));
    send(32'h0000_00AA);
    idle(3);
    check("range_recover_count", m_addr_q.size(), 1);
    check("range_recover_addr", (m_addr_q.size() == 1) ? m_addr_q[0] : 32'hFFFF, 0);
    check("range_recover_data", (m_data_q.size() == 1) ? m_data_q[0] : 32'hFFFF_FFFF, 32'hAA);

    // Reset clears the sticky error
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    check("rst2_err_clear", err, 0);

    // Illegal header and zero-count header
    clear_logs();
    send(hdr(2'd3, 8'd1, 8'd1));
    idle(1);
    check("illegal_err", err, 1);
    check("illegal_s_ready", s_ready, 1);
    send(hdr(2'd0, 8'd0, 8'd0));
    send(hdr(2'd0, 8'd5, 8'd1));
    send(32'h1234_5678);
    idle(3);
    check("zero_hdr_count", i_addr_q.size(), 1);
    check("zero_hdr_addr", (i_addr_q.size() == 1) ? i_addr_q[0] : 32'hFFFF, 5);
    check("zero_hdr_data", (i_data_q.size() == 1) ? i_data_q[0] : 32'hFFFF_FFFF, 32'h1234_5678);

    // Reset after two of five beats abandons the load
    clear_logs();
    send(hdr(2'd0, 8'd0, 8'd5));
    send(32'h0000_00C0);
    send(32'h0000_00C1);
    rst = 1'b1;
    idle(2);
    check_reset_values("midrst");
    rst = 1'b0;
    idle(3);
    check("midrst_strobes", i_addr_q.size(), 2);
    send(hdr(2'd0, 8'd10, 8'd2));
    send(32'h0000_0D00);
    send(32'h0000_0D01);
    idle(3);
    check("after_rst_count", i_addr_q.size(), 4);
    check("after_rst_addr", (i_addr_q.size() == 4) ? i_addr_q[3] : 32'hFFFF, 11);
    check("after_rst_data", (i_data_q.size() == 4) ? i_data_q[3] : 32'hFFFF_FFFF, 32'h0D01);

    check("no_strobe_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
